// File: rtl/nes_pad_reader_pkg.sv
// Shared NES pad constants: button bit positions, frame width, default poll timing.
// Also holds the FSM state encoding used by the pad reader.
package nes_pad_reader_pkg;

  localparam int NES_BITS  = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // 50 MHz core: 12 us latch, 6 us half-period, 60 Hz poll
  localparam int unsigned DEF_LATCH_CYCLES = 600;
  localparam int unsigned DEF_HALF_CYCLES  = 300;
  localparam int unsigned DEF_POLL_CYCLES  = 833333;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_UPDATE
  } pad_state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_pad_reader_if.sv
// Pad-side serial pins plus game-side button state; master is the reader, slave the pad/game.
// No backpressure: outputs are level/pulse signals the consumer must sample when buttons_valid fires.
interface nes_pad_reader_if;
  import nes_pad_reader_pkg::*;

  logic                nes_in;
  logic                nes_latch;
  logic                nes_clk;
  logic [NES_BITS-1:0] buttons;
  logic [NES_BITS-1:0] pressed;
  logic                buttons_valid;

  modport master (
    input  nes_in,
    output nes_latch, nes_clk, buttons, pressed, buttons_valid
  );

  modport slave (
    output nes_in,
    input  nes_latch, nes_clk, buttons, pressed, buttons_valid
  );

endinterface

// File: rtl/nes_pad_reader_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; 2-cycle latency, no backpressure.
// Reset value is a parameter so an idle-high line reads as inactive out of reset.
module nes_pad_reader_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls an NES pad each frame and reports held/newly-pressed buttons; result lands LATCH+15*HALF+1 cycles
// after frame start. No backpressure: buttons_valid/pressed are single-cycle pulses.
module nes_pad_reader
  import nes_pad_reader_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int unsigned HALF_CYCLES  = DEF_HALF_CYCLES,
  parameter int unsigned POLL_CYCLES  = DEF_POLL_CYCLES
) (
  input  logic             clk,
  input  logic             hard_reset,
  nes_pad_reader_if.master pad
);

  localparam int unsigned PH_W = $clog2(max2(LATCH_CYCLES, HALF_CYCLES));
  localparam int unsigned PW   = $clog2(POLL_CYCLES);

  pad_state_t          state, state_nxt;
  logic [PH_W-1:0]     phase;
  logic [PW-1:0]       poll_cnt;
  logic [2:0]          pulse_cnt;
  logic [NES_BITS-1:0] shift;
  logic                nes_sync;
  logic                phase_last;
  logic                sample_en;

  nes_pad_reader_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (hard_reset),
    .d   (pad.nes_in),
    .q   (nes_sync)
  );

  always_ff @(posedge clk) begin
    if (hard_reset) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (poll_cnt == '0) state_nxt = ST_LATCH;
      ST_LATCH:  if (phase_last) state_nxt = ST_GAP;
      ST_GAP:    if (phase_last) state_nxt = ST_CLK_HI;
      ST_CLK_HI: if (phase_last) state_nxt = ST_CLK_LO;
      ST_CLK_LO: if (phase_last) state_nxt = (pulse_cnt == 3'd7) ? ST_UPDATE : ST_CLK_HI;
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pad.nes_latch = 1'b0;
    pad.nes_clk   = 1'b0;
    phase_last    = 1'b0;
    case (state)
      ST_LATCH: begin
        pad.nes_latch = 1'b1;
        phase_last    = (phase == PH_W'(LATCH_CYCLES - 1));
      end
      ST_GAP, ST_CLK_LO: phase_last = (phase == PH_W'(HALF_CYCLES - 1));
      ST_CLK_HI: begin
        pad.nes_clk = 1'b1;
        phase_last  = (phase == PH_W'(HALF_CYCLES - 1));
      end
      default: ;
    endcase
    // bit0 is presented during latch; bits 1..7 settle while nes_clk is high
    sample_en = phase_last && (state == ST_LATCH || state == ST_CLK_HI);
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      poll_cnt  <= '0;
      phase     <= '0;
      pulse_cnt <= '0;
    end else begin
      poll_cnt <= (poll_cnt == PW'(POLL_CYCLES - 1)) ? '0 : poll_cnt + PW'(1);
      if (state_nxt != state || state == ST_IDLE || state == ST_UPDATE)
        phase <= '0;
      else
        phase <= phase + PH_W'(1);
      if (state == ST_LATCH)
        pulse_cnt <= '0;
      else if (state == ST_CLK_HI && phase_last)
        pulse_cnt <= pulse_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      shift             <= '0;
      pad.buttons       <= '0;
      pad.pressed       <= '0;
      pad.buttons_valid <= 1'b0;
    end else begin
      pad.pressed       <= '0;
      pad.buttons_valid <= 1'b0;
      if (sample_en)
        shift <= {nes_sync, shift[NES_BITS-1:1]};
      if (state == ST_UPDATE) begin
        pad.buttons       <= ~shift;
        pad.pressed       <= ~shift & ~pad.buttons;
        pad.buttons_valid <= 1'b1;
      end
    end
  end

endmodule
